change_dispenser: RTL and testbench

CHANGE_DISPENSER -- requirements
Module: change_dispenser

---
 rtl/piggy_pkg.sv | 35 +++
 rtl/coin_select.sv | 35 +++
 rtl/change_dispenser.sv | 94 +++++++++
 tb/tb_change_dispenser.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/piggy_pkg.sv
// Shared definitions for the change dispenser: coin values, denomination
// index order (bit positions in the empty/eject vectors) and FSM states.
package piggy_pkg;

  localparam logic [7:0] VAL_PENNY   = 8'd1;
  localparam logic [7:0] VAL_NICKEL  = 8'd5;
  localparam logic [7:0] VAL_DIME    = 8'd10;
  localparam logic [7:0] VAL_QUARTER = 8'd25;

  typedef enum logic [1:0] {
    COIN_PENNY   = 2'd0,
    COIN_NICKEL  = 2'd1,
    COIN_DIME    = 2'd2,
    COIN_QUARTER = 2'd3
  } coin_e;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DISPENSE = 2'd1,
    DONE     = 2'd2,
    FAULT    = 2'd3
  } state_t;

  function automatic logic [7:0] coin_value(input coin_e c);
    logic [7:0] v;
    case (c)
      COIN_QUARTER: v = VAL_QUARTER;
      COIN_DIME:    v = VAL_DIME;
      COIN_NICKEL:  v = VAL_NICKEL;
      default:      v = VAL_PENNY;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/coin_select.sv
// Greedy coin picker: largest non-empty denomination that still fits in the
// credit owed, as a one-hot vector plus its value; none=1 when nothing fits.
module coin_select
  import piggy_pkg::*;
(
  input  logic [7:0] remaining,
  input  logic [3:0] empty,
  output logic [3:0] coin,
  output logic [7:0] value,
  output logic       none
);

  // Priority chain quarter > dime > nickel > penny over eligible hoppers
  always_comb begin
    coin  = '0;
    value = '0;
    none  = 1'b0;
    if (!empty[COIN_QUARTER] && remaining >= coin_value(COIN_QUARTER)) begin
      coin[COIN_QUARTER] = 1'b1;
      value              = coin_value(COIN_QUARTER);
    end else if (!empty[COIN_DIME] && remaining >= coin_value(COIN_DIME)) begin
      coin[COIN_DIME] = 1'b1;
      value           = coin_value(COIN_DIME);
    end else if (!empty[COIN_NICKEL] && remaining >= coin_value(COIN_NICKEL)) begin
      coin[COIN_NICKEL] = 1'b1;
      value             = coin_value(COIN_NICKEL);
    end else if (!empty[COIN_PENNY] && remaining >= coin_value(COIN_PENNY)) begin
      coin[COIN_PENNY] = 1'b1;
      value            = coin_value(COIN_PENNY);
    end else begin
      none = 1'b1;
    end
  end

endmodule

// File: rtl/change_dispenser.sv
// Change dispenser: loads a credit, then ejects one coin per ready cycle
// (greedy) until the credit is paid out or no hopper can cover the rest.
module change_dispenser
  import piggy_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] amount,
  input  logic       ready,
  input  logic [3:0] empty,
  output logic       quarter,
  output logic       dime,
  output logic       nickel,
  output logic       penny,
  output logic       busy,
  output logic       done,
  output logic       fault,
  output logic [7:0] remaining
);

  state_t     state;
  logic [3:0] eject;
  logic [3:0] sel_coin;
  logic [7:0] sel_value;
  logic       sel_none;

  coin_select u_coin_select (
    .remaining (remaining),
    .empty     (empty),
    .coin      (sel_coin),
    .value     (sel_value),
    .none      (sel_none)
  );

  assign quarter = eject[COIN_QUARTER];
  assign dime    = eject[COIN_DIME];
  assign nickel  = eject[COIN_NICKEL];
  assign penny   = eject[COIN_PENNY];

  // Dispense FSM; coin and done outputs are one-cycle pulses, so they clear every edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      eject     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      fault     <= 1'b0;
      remaining <= '0;
    end else begin
      eject <= '0;
      done  <= 1'b0;
      case (state)
        IDLE, DONE, FAULT: begin
          if (start) begin
            remaining <= amount;
            fault     <= 1'b0;
            if (amount == 8'd0) begin
              state <= DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              state <= DISPENSE;
              busy  <= 1'b1;
            end
          end else if (state == DONE) begin
            state <= IDLE;
          end
        end
        DISPENSE: begin
          if (sel_none) begin
            state <= FAULT;
            fault <= 1'b1;
            busy  <= 1'b0;
          end else if (ready) begin
            remaining <= remaining - sel_value;
            eject     <= sel_coin;
            if (sel_value == remaining) begin
              state <= DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          fault <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_change_dispenser.sv
// Directed self-checking bench for change_dispenser with hand-computed expectations.
module tb_change_dispenser;

  logic       clk;
  logic       reset;
  logic       start;
  logic [7:0] amount;
  logic       ready;
  logic [3:0] empty;
  logic       quarter, dime, nickel, penny;
  logic       busy, done, fault;
  logic [7:0] remaining;

  int checkCount;
  int errorCount;
  int pulseCount;
  int expRem;

  change_dispenser dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .amount    (amount),
    .ready     (ready),
    .empty     (empty),
    .quarter   (quarter),
    .dime      (dime),
    .nickel    (nickel),
    .penny     (penny),
    .busy      (busy),
    .done      (done),
    .fault     (fault),
    .remaining (remaining)
  );

  // Free-running 10-unit clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [7:0] amt);
    amount = amt;
    start  = 1'b1;
    tick();
    start  = 1'b0;
  endtask

  function automatic logic [3:0] coins();
    return {quarter, dime, nickel, penny};
  endfunction

  // Directed scenario sequence
  initial begin
    checkCount = 0;
    errorCount = 0;
    reset  = 1'b1;
    start  = 1'b0;
    amount = 8'd0;
    ready  = 1'b1;
    empty  = 4'b0000;
    #3;
    checkOutput("reset_coins", {28'd0, coins()}, 32'd0);
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    checkOutput("reset_done", {31'd0, done}, 32'd0);
    checkOutput("reset_fault", {31'd0, fault}, 32'd0);
    checkOutput("reset_rem", {24'd0, remaining}, 32'd0);
    #9;
    reset = 1'b0;

    $display("[TB] amount=30 all hoppers full");
    applyStimulus(8'd30);
    checkOutput("a30_busy", {31'd0, busy}, 32'd1);
    checkOutput("a30_rem0", {24'd0, remaining}, 32'd30);
    checkOutput("a30_nocoin", {28'd0, coins()}, 32'd0);
    tick();
    checkOutput("a30_quarter", {28'd0, coins()}, 32'b1000);
    checkOutput("a30_rem1", {24'd0, remaining}, 32'd5);
    checkOutput("a30_done_early", {31'd0, done}, 32'd0);
    tick();
    checkOutput("a30_nickel", {28'd0, coins()}, 32'b0010);
    checkOutput("a30_done", {31'd0, done}, 32'd1);
    checkOutput("a30_rem2", {24'd0, remaining}, 32'd0);
    checkOutput("a30_busy_off", {31'd0, busy}, 32'd0);
    tick();
    checkOutput("a30_idle_done", {31'd0, done}, 32'd0);
    checkOutput("a30_idle_coins", {28'd0, coins()}, 32'd0);

    $display("[TB] amount=41 quarter hopper empty");
    empty = 4'b1000;
    applyStimulus(8'd41);
    expRem = 41;
    for (int i = 0; i < 4; i++) begin
      tick();
      expRem = expRem - 10;
      checkOutput("a41_dime", {28'd0, coins()}, 32'b0100);
      checkOutput("a41_rem", expRem, {24'd0, remaining});
    end
    tick();
    checkOutput("a41_penny", {28'd0, coins()}, 32'b0001);
    checkOutput("a41_done", {31'd0, done}, 32'd1);
    checkOutput("a41_rem_end", {24'd0, remaining}, 32'd0);
    tick();

    $display("[TB] amount=7 penny hopper empty");
    empty = 4'b0001;
    applyStimulus(8'd7);
    tick();
    checkOutput("a7_nickel", {28'd0, coins()}, 32'b0010);
    checkOutput("a7_rem", {24'd0, remaining}, 32'd2);
    tick();
    checkOutput("a7_fault", {31'd0, fault}, 32'd1);
    checkOutput("a7_fault_rem", {24'd0, remaining}, 32'd2);
    checkOutput("a7_fault_coins", {28'd0, coins()}, 32'd0);
    checkOutput("a7_fault_busy", {31'd0, busy}, 32'd0);
    tick();
    checkOutput("a7_fault_hold", {31'd0, fault}, 32'd1);
    applyStimulus(8'd0);
    checkOutput("a0_fault_clr", {31'd0, fault}, 32'd0);
    checkOutput("a0_done", {31'd0, done}, 32'd1);
    checkOutput("a0_nocoin", {28'd0, coins()}, 32'd0);
    checkOutput("a0_rem", {24'd0, remaining}, 32'd0);
    tick();
    checkOutput("a0_done_pulse", {31'd0, done}, 32'd0);

    $display("[TB] amount=255 ready alternating");
    empty = 4'b0000;
    applyStimulus(8'd255);
    pulseCount = 0;
    expRem = 255;
    for (int k = 0; k < 22; k++) begin
      ready = (k % 2 == 0);
      tick();
      if (coins() != 4'd0) pulseCount++;
      if (k % 2 == 1 || k == 21) begin
        checkOutput("a255_idle_cycle", {28'd0, coins()}, 32'd0);
      end else if (k < 20) begin
        expRem = expRem - 25;
        checkOutput("a255_quarter", {28'd0, coins()}, 32'b1000);
        checkOutput("a255_rem", expRem, {24'd0, remaining});
      end else begin
        checkOutput("a255_nickel", {28'd0, coins()}, 32'b0010);
        checkOutput("a255_done", {31'd0, done}, 32'd1);
        checkOutput("a255_rem_end", {24'd0, remaining}, 32'd0);
      end
    end
    checkOutput("a255_pulses", pulseCount, 32'd11);

    $display("[TB] start ignored during dispense");
    ready = 1'b0;
    applyStimulus(8'd30);
    amount = 8'd99;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    checkOutput("ign_rem", {24'd0, remaining}, 32'd30);
    checkOutput("ign_busy", {31'd0, busy}, 32'd1);
    checkOutput("ign_nocoin", {28'd0, coins()}, 32'd0);
    ready = 1'b1;
    tick();
    checkOutput("ign_quarter", {28'd0, coins()}, 32'b1000);
    checkOutput("ign_rem1", {24'd0, remaining}, 32'd5);
    tick();
    checkOutput("ign_done", {31'd0, done}, 32'd1);
    tick();

    $display("[TB] reset mid-dispense amount=100");
    applyStimulus(8'd100);
    tick();
    checkOutput("rst_pre_quarter", {28'd0, coins()}, 32'b1000);
    checkOutput("rst_pre_rem", {24'd0, remaining}, 32'd75);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("rst_coins", {28'd0, coins()}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_rem", {24'd0, remaining}, 32'd0);
    checkOutput("rst_done", {31'd0, done}, 32'd0);
    tick();
    checkOutput("rst_hold_coins", {28'd0, coins()}, 32'd0);
    #2;
    reset = 1'b0;
    tick();
    checkOutput("rst_after_coins", {28'd0, coins()}, 32'd0);
    checkOutput("rst_after_busy", {31'd0, busy}, 32'd0);
    tick();
    checkOutput("rst_after_coins2", {28'd0, coins()}, 32'd0);
    checkOutput("rst_after_rem", {24'd0, remaining}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
